k285_sync_ctrl: RTL and testbench
=================================

# k285_sync_ctrl

Word-synchronization controller for the serial 8b10b receive path. It consumes the per-bit comma flag `esk285` from the K28.5 detector and tracks the 10-bit word phase with a bit counter. A three-state machine acquires, holds and drops link alignment. The block emits word strobes, a sync indication and a detector reset pulse on loss of sync, and sits between the K28.5 detector and the 10b/8b decoder.

## Interface

- `ACQ_COMMAS`, 3: consecutive aligned commas required to declare sync (1..7)
- `MISALIGN_LIMIT`, 2: misaligned commas tolerated in SYNC before dropping (1..7)
- `TIMEOUT_WORDS`, 16: words without any comma before dropping ACQ/SYNC (1..255)
- `clk` input 1: clock, all state on rising edge
- `rst` input 1: asynchronous, active-high reset
- `enb` input 1: bit-time enable; when low, all state holds and `esk285` is ignored
- `esk285` input 1: detector flag; high means the 10 bits ending with the current bit are K28.5
- `detRst` output 1: reset request to the detector
- `bitCnt` output 4: word phase 0..9; 9 marks the last bit of a word
- `wordStrobe` output 1: combinational `enb && syncOk && bitCnt==9`
- `syncOk` output 1: registered, high while in SYNC
- `state` output 2: 0=LOSS, 1=ACQ, 2=SYNC
- `lossCnt` output 8: sync-loss event counter (see Configuration)

## Operation

- Aligned comma: `esk285 && bitCnt==9`.
- Misaligned comma: `esk285 && bitCnt!=9`.
- `bitCnt` increments modulo 10 on each enabled cycle.
- Realign: `bitCnt` is set to 0 on the next edge, making the comma bit the word end.
- `commaCnt` is 3 bits, `missCnt` is 3 bits, `wordCnt` is 8 bits.
- `wordCnt` increments at `bitCnt==9`, clears on any comma, and saturates at 255.
- LOSS:
  - Any `esk285` realigns, sets `commaCnt=1`, and moves to ACQ.
  - If `ACQ_COMMAS==1`, any `esk285` instead goes directly to SYNC.
- ACQ:
  - Aligned comma increments `commaCnt`; reaching `ACQ_COMMAS` moves to SYNC with `missCnt=0`.
  - Misaligned comma realigns, sets `commaCnt=1`, and stays in ACQ.
  - When `wordCnt` reaches `TIMEOUT_WORDS`, move to LOSS.
- SYNC:
  - Aligned comma clears `missCnt`.
  - Misaligned comma increments `missCnt` and does not realign; reaching `MISALIGN_LIMIT` moves to LOSS.
  - When `wordCnt` reaches `TIMEOUT_WORDS`, move to LOSS.
- Every transition into LOSS from ACQ or SYNC:
  - `detRst` is high for exactly one cycle.
  - `commaCnt`, `missCnt` and `wordCnt` clear.
- When a comma and a timeout occur in the same cycle, the comma wins and the timeout is discarded.

## Timing

- Reset values:
  - `state`=LOSS, `bitCnt`=0, `syncOk`=0, `wordStrobe`=0, `lossCnt`=0.
  - `detRst`=1; it falls at the first enabled edge after `rst` deasserts.
  - All internal counters are 0.
- Asserting `rst` mid-operation returns all of the above immediately, without waiting for a clock.
- Comma-to-state latency is 1 cycle. `syncOk` rises on the same edge that `state` becomes SYNC.
- After a realign at edge N, `bitCnt` is 0 at N, and the next aligned comma is possible at N+10.
- `wordStrobe` first pulses 9 enabled cycles after entry to SYNC, when entry coincides with a realign.
- `enb` low holds everything, including a pending `detRst`.

## Configuration

- `K285_SYNC_STATS_EN` defined:
  - `lossCnt` increments, saturating at 255, on every transition into LOSS from ACQ or SYNC.
  - Its value is cleared only by `rst`.
- `K285_SYNC_STATS_EN` undefined:
  - The counter logic is compiled out and `lossCnt` is driven constant 0.
  - All other behaviour is identical.

## Test plan

- Reset then clean acquisition:
  - Stimulus: `rst` pulse, `enb`=1, `esk285` pulses at cycles 5, 15, 25 (defaults).
  - Response: state 0→1 at 6, SYNC at 26, `syncOk`=1 at 26, first `wordStrobe` at 35.
- Misaligned comma in ACQ:
  - Stimulus: pulses at 5, 15, 22, 32, 42.
  - Response: realign at 23 with `commaCnt`=1, SYNC at 43.
- SYNC misalignment:
  - Stimulus: after SYNC, 2 misaligned commas.
  - Response: LOSS one cycle after the 2nd, `detRst` 1-cycle pulse, `bitCnt` not realigned by the 1st.
  - Stimulus: an aligned comma between the two misaligned commas.
  - Response: stays in SYNC.
- Timeout:
  - Stimulus: in SYNC, `esk285` held 0 for 160 enabled cycles.
  - Response: LOSS after the 16th word end.
  - Stimulus: a comma at that same word end.
  - Response: stays in SYNC.
- Enable and async reset:
  - Stimulus: `enb` low for 7 cycles mid-word.
  - Response: `bitCnt` and `state` frozen, `esk285` ignored.
  - Stimulus: `rst` raised between clock edges.
  - Response: outputs return to reset values immediately.
- Stats macro:
  - With `K285_SYNC_STATS_EN`: force 3 sync losses, then `lossCnt`=3; 300 losses give 255.
  - Without the macro: `lossCnt`=0 throughout.

Source files
------------

// File: rtl/k285_sync_ctrl.sv
// k285_sync_ctrl: word-synchronization controller for the serial 8b10b
// receive path. Tracks the 10-bit word phase from the per-bit K28.5 flag and
// acquires, holds and drops alignment with a LOSS/ACQ/SYNC state machine.
// Build option: define K285_SYNC_STATS_EN to include the sync-loss event
// counter on lossCnt; otherwise lossCnt is tied to zero.
module k285_sync_ctrl #(
  parameter int unsigned ACQ_COMMAS     = 3,
  parameter int unsigned MISALIGN_LIMIT = 2,
  parameter int unsigned TIMEOUT_WORDS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       esk285,
  output logic       detRst,
  output logic [3:0] bitCnt,
  output logic       wordStrobe,
  output logic       syncOk,
  output logic [1:0] state,
  output logic [7:0] lossCnt
);

  typedef enum logic [1:0] {
    ST_LOSS = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  localparam logic [3:0] ACQ_N     = 4'(ACQ_COMMAS);
  localparam logic [3:0] MISS_N    = 4'(MISALIGN_LIMIT);
  localparam logic [8:0] TIMEOUT_N = 9'(TIMEOUT_WORDS);
  localparam logic [3:0] LAST_BIT  = 4'd9;

  state_e     state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [2:0] commaCnt_q, commaCnt_d;
  logic [2:0] missCnt_q, missCnt_d;
  logic [7:0] wordCnt_q, wordCnt_d;
  logic       syncOk_q, syncOk_d;
  logic       detRst_q, detRst_d;

  logic       word_end;
  logic       aligned;
  logic       misaligned;
  logic       timeout;
  logic       realign;
  logic       to_loss;
  logic [3:0] comma_inc;
  logic [3:0] miss_inc;
  logic [8:0] word_inc;

  assign word_end   = (bitCnt_q == LAST_BIT);
  assign aligned    = esk285 && word_end;
  assign misaligned = esk285 && !word_end;
  assign comma_inc  = {1'b0, commaCnt_q} + 4'd1;
  assign miss_inc   = {1'b0, missCnt_q} + 4'd1;
  assign word_inc   = {1'b0, wordCnt_q} + 9'd1;
  // A comma in the same cycle suppresses the timeout.
  assign timeout    = word_end && !esk285 && (word_inc >= TIMEOUT_N);
  assign to_loss    = enb && (state_q != ST_LOSS) && (state_d == ST_LOSS);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOSS;
    else     state_q <= state_d;
  end

  // Next-state logic plus the comma/miss counters that steer it.
  always_comb begin
    state_d    = state_q;
    commaCnt_d = commaCnt_q;
    missCnt_d  = missCnt_q;
    realign    = 1'b0;
    if (enb) begin
      case (state_q)
        ST_LOSS: begin
          if (esk285) begin
            realign    = 1'b1;
            commaCnt_d = 3'd1;
            if (ACQ_N <= 4'd1) begin
              state_d   = ST_SYNC;
              missCnt_d = 3'd0;
            end else begin
              state_d = ST_ACQ;
            end
          end
        end
        ST_ACQ: begin
          if (aligned) begin
            commaCnt_d = comma_inc[2:0];
            if (comma_inc >= ACQ_N) begin
              state_d   = ST_SYNC;
              missCnt_d = 3'd0;
            end
          end else if (misaligned) begin
            realign    = 1'b1;
            commaCnt_d = 3'd1;
          end else if (timeout) begin
            state_d    = ST_LOSS;
            commaCnt_d = 3'd0;
            missCnt_d  = 3'd0;
          end
        end
        ST_SYNC: begin
          if (aligned) begin
            missCnt_d = 3'd0;
          end else if (misaligned) begin
            // In SYNC a stray comma is counted but never moves the word phase.
            if (miss_inc >= MISS_N) begin
              state_d    = ST_LOSS;
              commaCnt_d = 3'd0;
              missCnt_d  = 3'd0;
            end else begin
              missCnt_d = miss_inc[2:0];
            end
          end else if (timeout) begin
            state_d    = ST_LOSS;
            commaCnt_d = 3'd0;
            missCnt_d  = 3'd0;
          end
        end
        default: begin
          state_d    = ST_LOSS;
          commaCnt_d = 3'd0;
          missCnt_d  = 3'd0;
        end
      endcase
    end
  end

  // Output/datapath logic: word phase, word counter, registered flags.
  always_comb begin
    bitCnt_d  = bitCnt_q;
    wordCnt_d = wordCnt_q;
    detRst_d  = detRst_q;
    syncOk_d  = syncOk_q;
    if (enb) begin
      bitCnt_d = (realign || word_end) ? 4'd0 : bitCnt_q + 4'd1;
      if (to_loss || esk285)
        wordCnt_d = 8'd0;
      else if (word_end)
        wordCnt_d = (wordCnt_q == 8'hFF) ? 8'hFF : word_inc[7:0];
      detRst_d = to_loss;
      syncOk_d = (state_d == ST_SYNC);
    end
  end

  // Datapath registers; detRst powers up asserted so the detector starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt_q   <= 4'd0;
      commaCnt_q <= 3'd0;
      missCnt_q  <= 3'd0;
      wordCnt_q  <= 8'd0;
      syncOk_q   <= 1'b0;
      detRst_q   <= 1'b1;
    end else begin
      bitCnt_q   <= bitCnt_d;
      commaCnt_q <= commaCnt_d;
      missCnt_q  <= missCnt_d;
      wordCnt_q  <= wordCnt_d;
      syncOk_q   <= syncOk_d;
      detRst_q   <= detRst_d;
    end
  end

`ifdef K285_SYNC_STATS_EN
  logic [7:0] lossCnt_q, lossCnt_d;

  assign lossCnt_d = (to_loss && (lossCnt_q != 8'hFF)) ? lossCnt_q + 8'd1 : lossCnt_q;

  // Saturating sync-loss event counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lossCnt_q <= 8'd0;
    else     lossCnt_q <= lossCnt_d;
  end

  assign lossCnt = lossCnt_q;
`else
  assign lossCnt = 8'd0;
`endif

  assign state      = state_q;
  assign bitCnt     = bitCnt_q;
  assign syncOk     = syncOk_q;
  assign detRst     = detRst_q;
  assign wordStrobe = enb && syncOk_q && word_end;

endmodule

// File: tb/tb_k285_sync_ctrl.sv
// tb_k285_sync_ctrl: directed vector table for k285_sync_ctrl plus
// hand-written sequences for enable hold, async reset and loss counting.
module tb_k285_sync_ctrl;

`ifdef K285_SYNC_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // Clock / reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       esk285;
  logic       detRst;
  logic [3:0] bitCnt;
  logic       wordStrobe;
  logic       syncOk;
  logic [1:0] state;
  logic [7:0] lossCnt;

  always #5 clk = ~clk;

  k285_sync_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .esk285     (esk285),
    .detRst     (detRst),
    .bitCnt     (bitCnt),
    .wordStrobe (wordStrobe),
    .syncOk     (syncOk),
    .state      (state),
    .lossCnt    (lossCnt)
  );

  // Vector table: 'idle' cycles with esk285=0, then one cycle with 'esk',
  // all at the row's enb; expected outputs are checked after the last edge.
  typedef struct {
    logic       enb;
    int         idle;
    logic       esk;
    logic [1:0] st;
    logic [3:0] bc;
    logic       so;
    logic       dr;
    logic       ws;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   losses   = 0;

  function automatic logic [7:0] exp_loss(input int n);
    logic [7:0] sat;
    sat = (n > 255) ? 8'd255 : 8'(n);
    return STATS_EN ? sat : 8'd0;
  endfunction

  task automatic add(input logic e, input int idle, input logic k,
                     input logic [1:0] st, input logic [3:0] bc,
                     input logic so, input logic dr, input logic ws);
    vec_t v;
    v.enb = e; v.idle = idle; v.esk = k;
    v.st = st; v.bc = bc; v.so = so; v.dr = dr; v.ws = ws;
    tbl.push_back(v);
  endtask

  // Driver tasks
  task automatic step(input logic e, input logic k);
    enb    = e;
    esk285 = k;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input int idle, input logic k);
    for (int i = 0; i < idle; i++) step(e, 1'b0);
    step(e, k);
  endtask

  // Scoreboard
  task automatic check(input string what, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", what, id, act, exp);
    end
  endtask

  task automatic check_all(input int id, input logic [1:0] st, input logic [3:0] bc,
                           input logic so, input logic dr, input logic ws,
                           input logic [7:0] lc);
    check("state",      id, 32'(state),      32'(st));
    check("bitCnt",     id, 32'(bitCnt),     32'(bc));
    check("syncOk",     id, 32'(syncOk),     32'(so));
    check("detRst",     id, 32'(detRst),     32'(dr));
    check("wordStrobe", id, 32'(wordStrobe), 32'(ws));
    check("lossCnt",    id, 32'(lossCnt),    32'(lc));
  endtask

  initial begin
    // Clean acquisition: commas at word phase 4, then two aligned.
    add(1, 4,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd2, 4'd0, 1, 0, 0);
    add(1, 8,   0, 2'd2, 4'd9, 1, 0, 1);
    // SYNC: two misaligned commas drop sync without realigning.
    add(1, 3,   1, 2'd2, 4'd3, 1, 0, 0);
    add(1, 5,   1, 2'd0, 4'd9, 0, 1, 0);
    add(1, 0,   0, 2'd0, 4'd0, 0, 0, 0);
    // SYNC: aligned comma between misaligned ones clears the miss count.
    add(1, 2,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd2, 4'd0, 1, 0, 0);
    add(1, 4,   1, 2'd2, 4'd5, 1, 0, 0);
    add(1, 4,   1, 2'd2, 4'd0, 1, 0, 0);
    add(1, 2,   1, 2'd2, 4'd3, 1, 0, 0);
    add(1, 1,   1, 2'd0, 4'd5, 0, 1, 0);
    add(1, 0,   0, 2'd0, 4'd6, 0, 0, 0);
    // ACQ: misaligned comma realigns and restarts the comma count at 1.
    add(1, 0,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 6,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd2, 4'd0, 1, 0, 0);
    // SYNC timeout at the 16th word end without a comma.
    add(1, 158, 0, 2'd2, 4'd9, 1, 0, 1);
    add(1, 0,   0, 2'd0, 4'd0, 0, 1, 0);
    add(1, 0,   0, 2'd0, 4'd1, 0, 0, 0);
    // Comma on the 16th word end wins over the timeout.
    add(1, 0,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 9,   1, 2'd2, 4'd0, 1, 0, 0);
    add(1, 158, 0, 2'd2, 4'd9, 1, 0, 1);
    add(1, 0,   1, 2'd2, 4'd0, 1, 0, 0);
    add(1, 158, 0, 2'd2, 4'd9, 1, 0, 1);
    add(1, 0,   0, 2'd0, 4'd0, 0, 1, 0);
    // ACQ timeout.
    add(1, 0,   1, 2'd1, 4'd0, 0, 0, 0);
    add(1, 158, 0, 2'd1, 4'd9, 0, 0, 0);
    add(1, 0,   0, 2'd0, 4'd0, 0, 1, 0);

    // Reset state
    rst    = 1'b1;
    enb    = 1'b0;
    esk285 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(100, 2'd0, 4'd0, 0, 1, 0, 8'd0);
    rst = 1'b0;

    // Table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].enb, tbl[i].idle, tbl[i].esk);
      if (tbl[i].enb && tbl[i].dr) losses++;
      check_all(i, tbl[i].st, tbl[i].bc, tbl[i].so, tbl[i].dr, tbl[i].ws,
                exp_loss(losses));
    end

    // enb low holds a pending detRst and ignores esk285.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check_all(200 + i, 2'd0, 4'd0, 0, 1, 0, exp_loss(losses));
    end
    step(1'b1, 1'b0);
    check_all(210, 2'd0, 4'd1, 0, 0, 0, exp_loss(losses));

    // enb low for 7 cycles mid-word in SYNC freezes phase and state.
    drive(1, 0, 1);
    drive(1, 9, 1);
    drive(1, 9, 1);
    check_all(220, 2'd2, 4'd0, 1, 0, 0, exp_loss(losses));
    drive(1, 3, 0);
    check_all(221, 2'd2, 4'd4, 1, 0, 0, exp_loss(losses));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1);
      check_all(230 + i, 2'd2, 4'd4, 1, 0, 0, exp_loss(losses));
    end
    drive(1, 4, 0);
    check_all(240, 2'd2, 4'd9, 1, 0, 1, exp_loss(losses));

    // rst raised between clock edges takes effect immediately.
    #3;
    rst = 1'b1;
    #1;
    check_all(250, 2'd0, 4'd0, 0, 1, 0, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all(251, 2'd0, 4'd0, 0, 1, 0, 8'd0);
    losses = 0;
    step(1'b1, 1'b0);
    check_all(252, 2'd0, 4'd1, 0, 0, 0, 8'd0);

    // 300 forced sync losses: lossCnt reaches 3, then saturates.
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 1);
      drive(1, 9, 1);
      drive(1, 9, 1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      losses++;
      check("loss_state", 300 + i, 32'(state), 32'(0));
      if (i == 2) check("lossCnt_3", 302, 32'(lossCnt), 32'(exp_loss(losses)));
    end
    check("lossCnt_sat", 600, 32'(lossCnt), 32'(exp_loss(losses)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
